// File: rtl/types.sv
//------------------------------------------------------------------------------
// types
// Shared type and constant package for the wall-clock blocks.
//   bcd_t        : one BCD digit
//   uart_state_t : byte-serializer states
//   time_snap_t  : the six two-digit time fields latched for one message
//   bcd_char()   : BCD digit to ASCII, '?' for a non-decimal nibble
//------------------------------------------------------------------------------
`default_nettype none

package types;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  localparam int MSG_LEN = 21;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_Q     = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_2     = 8'h32;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  typedef struct packed {
    bcd_t [1:0] year;
    bcd_t [1:0] month;
    bcd_t [1:0] day;
    bcd_t [1:0] hour;
    bcd_t [1:0] minute;
    bcd_t [1:0] second;
  } time_snap_t;

  function automatic logic [7:0] bcd_char(input bcd_t d);
    logic [7:0] c;
    if (d > 4'd9) c = ASCII_Q;
    else          c = ASCII_0 + {4'd0, d};
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// uart_tx
// 8N1 byte serializer with a valid/ready handshake.
//   clk, rst  : clock, asynchronous active-high reset
//   valid_i   : byte offered on data_i
//   data_i    : byte to send, LSB first
//   ready_o   : high only while idle; a byte is taken on valid_i & ready_o
//   done_o    : one-cycle pulse on the last clock of the stop bit
//   txd_o     : serial line, idle high
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx
  import types::*;
#(
  parameter int BIT_CYCLES = 208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       txd_o
);

  localparam int            CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready_o = (state_q == UART_IDLE);
  assign done_o  = (state_q == UART_STOP) && bit_end;
  assign txd_o   = txd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      UART_IDLE: begin
        cnt_d = '0;
        if (valid_i) begin
          state_d = UART_START;
          shift_d = data_i;
        end
      end
      UART_START: begin
        if (bit_end) begin
          state_d = UART_DATA;
          bit_d   = 3'd0;
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = UART_STOP;
        end
      end
      default: begin
        if (bit_end) state_d = UART_IDLE;
      end
    endcase
  end

  // The line level is registered from the current state, so it trails the
  // state by one clock; every bit still lasts exactly BIT_CYCLES clocks.
  always_comb begin
    case (state_q)
      UART_START: txd_d = 1'b0;
      UART_DATA:  txd_d = shift_q[0];
      default:    txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/time_uart_tx.sv
//------------------------------------------------------------------------------
// time_uart_tx
// Sends "20YY-MM-DD hh:mm:ss\r\n" over an 8N1 UART each time the BCD second
// input changes. At most one further message is queued while one is in flight.
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : allow new messages to start
//   year .. second      : live BCD time, [1] tens digit, [0] units digit
//   txd                 : serial output, idle high
//   busy                : high from message start to end of final stop bit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module time_uart_tx
  import types::*;
#(
  parameter int CLK_FREQ = 24_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  bcd_t [1:0] year,
  input  bcd_t [1:0] month,
  input  bcd_t [1:0] day,
  input  bcd_t [1:0] hour,
  input  bcd_t [1:0] minute,
  input  bcd_t [1:0] second,
  output logic       txd,
  output logic       busy
);

  localparam int         BIT_CYCLES = CLK_FREQ / BAUD;
  localparam logic [0:0] MSG_IDLE   = 1'b0;
  localparam logic [0:0] MSG_SEND   = 1'b1;
  localparam logic [4:0] LAST_IDX   = 5'(MSG_LEN - 1);

  bcd_t [1:0] second_q;
  logic       armed_q;
  logic [0:0] msg_q, msg_d;
  logic [4:0] idx_q, idx_d;
  logic       last_q, last_d;        // final character already handed over
  logic       pending_q, pending_d;
  time_snap_t snap_q, snap_d;

  time_snap_t live;
  logic       tick, valid, ready, done, accept, msg_end;
  logic [7:0] char_w;

  assign live    = {year, month, day, hour, minute, second};
  assign tick    = (second != second_q) && armed_q;
  assign valid   = (msg_q == MSG_SEND) && !last_q;
  assign accept  = valid && ready;
  assign msg_end = (msg_q == MSG_SEND) && last_q && done;
  assign busy    = (msg_q == MSG_SEND);

  always_comb begin
    msg_d     = msg_q;
    idx_d     = idx_q;
    last_d    = last_q;
    pending_d = pending_q;
    snap_d    = snap_q;
    case (msg_q)
      MSG_IDLE: begin
        if (tick && en) begin
          msg_d  = MSG_SEND;
          idx_d  = 5'd0;
          last_d = 1'b0;
          snap_d = live;
        end
      end
      default: begin
        if (msg_end) begin
          // A tick landing on the end edge is folded into the restart: the
          // live snapshot taken here already contains it.
          pending_d = 1'b0;
          if (en && (pending_q || tick)) begin
            snap_d = live;
            idx_d  = 5'd0;
            last_d = 1'b0;
          end else begin
            msg_d = MSG_IDLE;
          end
        end else begin
          if (accept) begin
            if (idx_q == LAST_IDX) last_d = 1'b1;
            else                   idx_d  = idx_q + 5'd1;
          end
          if (tick && en) pending_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    case (idx_q)
      5'd0:    char_w = ASCII_2;
      5'd1:    char_w = ASCII_0;
      5'd2:    char_w = bcd_char(snap_q.year[1]);
      5'd3:    char_w = bcd_char(snap_q.year[0]);
      5'd4:    char_w = ASCII_DASH;
      5'd5:    char_w = bcd_char(snap_q.month[1]);
      5'd6:    char_w = bcd_char(snap_q.month[0]);
      5'd7:    char_w = ASCII_DASH;
      5'd8:    char_w = bcd_char(snap_q.day[1]);
      5'd9:    char_w = bcd_char(snap_q.day[0]);
      5'd10:   char_w = ASCII_SPACE;
      5'd11:   char_w = bcd_char(snap_q.hour[1]);
      5'd12:   char_w = bcd_char(snap_q.hour[0]);
      5'd13:   char_w = ASCII_COLON;
      5'd14:   char_w = bcd_char(snap_q.minute[1]);
      5'd15:   char_w = bcd_char(snap_q.minute[0]);
      5'd16:   char_w = ASCII_COLON;
      5'd17:   char_w = bcd_char(snap_q.second[1]);
      5'd18:   char_w = bcd_char(snap_q.second[0]);
      5'd19:   char_w = ASCII_CR;
      default: char_w = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      second_q  <= '0;
      armed_q   <= 1'b0;
      msg_q     <= MSG_IDLE;
      idx_q     <= 5'd0;
      last_q    <= 1'b0;
      pending_q <= 1'b0;
      snap_q    <= '0;
    end else begin
      second_q  <= second;
      armed_q   <= 1'b1;
      msg_q     <= msg_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
    end
  end

  uart_tx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .valid_i(valid),
    .data_i (char_w),
    .ready_o(ready),
    .done_o (done),
    .txd_o  (txd)
  );

endmodule

`default_nettype wire

// File: tb/tb_time_uart_tx.sv
//------------------------------------------------------------------------------
// tb_time_uart_tx
// Self-checking bench for time_uart_tx, run with 4 clocks per bit so that one
// message takes 21 * (10*4 + 1) = 861 clocks.
//------------------------------------------------------------------------------
`default_nettype none

module tb_time_uart_tx;
  import types::*;

  localparam int B       = 4;
  localparam int MSG_CYC = 21 * (10 * B + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  bcd_t [1:0] year, month, day, hour, minute, second;
  logic       txd, busy;

  time_uart_tx #(.CLK_FREQ(40), .BAUD(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .year  (year),
    .month (month),
    .day   (day),
    .hour  (hour),
    .minute(minute),
    .second(second),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: samples mid-bit on negative edges, abandons a frame on reset.
  logic [7:0] rx_q[$];
  logic [7:0] mon_byte;
  logic       mon_act = 1'b0;
  int         mon_cnt, frame_err = 0;
  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (txd === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt = mon_cnt + 1;
      if (mon_cnt % B == B / 2) begin
        if (mon_cnt / B == 0) begin
          if (txd !== 1'b0) mon_act = 1'b0;
        end else if (mon_cnt / B <= 8) begin
          mon_byte[mon_cnt / B - 1] = txd;
        end else begin
          if (txd !== 1'b1) frame_err = frame_err + 1;
          rx_q.push_back(mon_byte);
          mon_act = 1'b0;
        end
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_msg(input string nm, input logic [167:0] act, input logic [167:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [167:0] pop_msg();
    logic [167:0] m = '0;
    logic [7:0]   b;
    for (int i = 0; i < 21; i++) begin
      b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      m = {m[159:0], b};
    end
    return m;
  endfunction

  typedef struct packed {
    logic [7:0]   yr, mo, dy, hr, mi, s0, s1;
    logic [167:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic set_time(input vec_t v, input logic [7:0] s);
    year = v.yr; month = v.mo; day = v.dy; hour = v.hr; minute = v.mi; second = s;
  endtask

  task automatic wait_fall(output int t);
    int n = 0;
    while (busy === 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    t = cyc;
  endtask

  // Load fields with en low (no message), then change second with en high.
  task automatic start_msg(input vec_t v, output int t_e);
    en = 1'b0;
    @(negedge clk) set_time(v, v.s0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    rx_q.delete();
    @(negedge clk) second = v.s1;
    @(posedge clk); #1;
    t_e = cyc;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int t_e, t_f, n;
    start_msg(v, t_e);
    chk({nm, " busy_rise"}, int'(busy), 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (txd !== 1'b0 && n < 20);
    chk({nm, " txd_latency"}, n, 2);
    wait_fall(t_f);
    chk({nm, " busy_len"}, t_f - t_e, MSG_CYC);
    repeat (5) @(negedge clk);
    chk({nm, " byte_count"}, rx_q.size(), 21);
    chk_msg({nm, " text"}, pop_msg(), v.exp);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  int t_e, t_f, t0, flag, flag2;

  initial begin
    vecs[0] = '{8'h24, 8'h05, 8'h17, 8'h13, 8'h45, 8'h37, 8'h38, "2024-05-17 13:45:38\r\n"};
    vecs[1] = '{8'h24, 8'h05, 8'h17, 8'h1B, 8'h45, 8'h38, 8'h39, "2024-05-17 1?:45:39\r\n"};
    vecs[2] = '{8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58, 8'h59, "2099-12-31 23:59:59\r\n"};
    vecs[3] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h59, 8'h00, "2000-01-01 00:00:00\r\n"};
    vecs[4] = '{8'hA5, 8'h1F, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h01, "20?5-1?-00 00:?0:01\r\n"};

    // Reset values, then idle with a non-zero second held through release.
    en = 1'b1;
    set_time(vecs[0], 8'h37);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset txd", int'(txd), 1);
    chk("reset busy", int'(busy), 0);
    @(negedge clk) rst = 1'b0;
    flag = 0; flag2 = 0;
    repeat (2000) begin
      @(negedge clk);
      if (busy !== 1'b0) flag = 1;
      if (txd !== 1'b1) flag2 = 1;
    end
    chk("post-reset busy seen", flag, 0);
    chk("post-reset txd low seen", flag2, 0);
    chk("post-reset bytes", rx_q.size(), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // en low at the tick: nothing sent.
    en = 1'b0;
    @(negedge clk) second = 8'h42;
    flag = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy !== 1'b0) flag = 1;
    end
    chk("en0 busy seen", flag, 0);
    chk("en0 bytes", rx_q.size(), 0);

    // en dropped mid-message with a pending tick: message completes, pending dropped.
    start_msg(vecs[0], t_e);
    repeat (300) @(negedge clk);
    second = 8'h39;
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_fall(t_f);
    chk("endrop busy_len", t_f - t_e, MSG_CYC);
    flag = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy !== 1'b0) flag = 1;
    end
    chk("endrop restart seen", flag, 0);
    chk("endrop byte_count", rx_q.size(), 21);
    chk_msg("endrop text", pop_msg(), vecs[0].exp);

    // Second changes every 100 clocks: four messages run back to back
    // (snapshots at 0, 861, 1722, 2583 clocks after the first tick).
    en = 1'b0;
    @(negedge clk) set_time(vecs[3], 8'h00);
    repeat (3) @(negedge clk);
    en = 1'b1;
    rx_q.delete();
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk) second = to_bcd(k + 1);
          repeat (99) @(negedge clk);
        end
      end
      begin
        int n = 0;
        while (busy !== 1'b1 && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        t0 = cyc;
        wait_fall(t_f);
      end
    join
    chk("b2b busy_len", t_f - t0, 4 * MSG_CYC);
    repeat (5) @(negedge clk);
    chk("b2b byte_count", rx_q.size(), 84);
    chk_msg("b2b msg1", pop_msg(), "2000-01-01 00:00:01\r\n");
    chk_msg("b2b msg2", pop_msg(), "2000-01-01 00:00:09\r\n");
    chk_msg("b2b msg3", pop_msg(), "2000-01-01 00:00:18\r\n");
    chk_msg("b2b msg4", pop_msg(), "2000-01-01 00:00:20\r\n");

    // Asynchronous reset during the data bits of the 5th character.
    start_msg(vecs[0], t_e);
    repeat (175) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset txd", int'(txd), 1);
    chk("midreset busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    run_vec(vecs[0], "after_reset");

    chk("frame errors", frame_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
